sipo_deserializer: RTL
======================

# sipo_deserializer

Parametrised serial-to-parallel deserializer with valid/ready handshakes on both sides. It collects WIDTH serial bits into a word, in MSB-first or LSB-first order, and presents the word in an output holding register. It sits between a bit-serial source (UART/SPI-style receiver front end) and word-wide consumers. It is the successor to the fixed 4-bit SIPO register, adding width/order parameters, flow control and word framing.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2.
- MSB_FIRST, 1, 1: first received bit lands in bit WIDTH-1; 0: first received bit lands in bit 0.
- CNT_W, $clog2(WIDTH), derived localparam, width of bit_count; not overridable.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear; discards the partial word and the held word.
- serial_in  in  1  serial data bit; sampled when in_valid && in_ready.
- in_valid  in  1  serial_in carries a bit this cycle.
- in_ready  out  1  block accepts a bit this cycle.
- parallel_out  out  WIDTH  assembled word; meaningful only when out_valid = 1.
- out_valid  out  1  parallel_out holds a complete word.
- out_ready  in  1  consumer takes the word this cycle.
- bit_count  out  CNT_W  number of bits accepted into the current partial word, 0..WIDTH-1.

## Operation
- Bit accept is in_valid && in_ready. Word transfer is out_valid && out_ready.
- Shift register sr[WIDTH-1:0] on each accepted bit:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], serial_in}.
  - MSB_FIRST=0: sr <= {serial_in, sr[WIDTH-1:1]}.
- On accepts with bit_count < WIDTH-1, bit_count increments.
- On the last bit (accept with bit_count == WIDTH-1):
  - The full word is the shifted value including serial_in, formed combinationally.
  - The word is loaded into the holding register; out_valid is set; bit_count wraps to 0.
- Holding register:
  - out_valid clears on a transfer, unless a new word loads in the same cycle; then it stays 1 with the new data.
- in_ready = !(bit_count == WIDTH-1 && out_valid && !out_ready).
  - The block stalls only when the last bit would overwrite an un-taken word.
  - in_ready is combinational from out_ready; no other combinational path.
- Partial words: bits may arrive with arbitrary in_valid gaps. The partial word is held indefinitely; there is no timeout.
- clear: next edge sets bit_count=0, sr=0, holding register=0, out_valid=0.
  - clear has priority over a simultaneous accept or transfer; the accepted bit and any word are dropped.
- Reset (reset_n=0, asynchronous, any time including mid-word):
  - bit_count=0, sr=0, parallel_out=0, out_valid=0.
  - in_ready reads 1 during and after reset.

## Timing
- Latency: out_valid rises on the edge that accepts the WIDTH-th bit. It is visible the cycle after that bit is presented.
- Throughput: one bit per cycle sustained. With out_ready held 1 there are no stall cycles and back-to-back words are allowed.
- Output stability: with out_valid=1 and out_ready=0, parallel_out and out_valid hold stable.
- Simultaneous last-bit and transfer: in_ready=1. The old word leaves and the new word loads on the same edge.
- Reset release: the first accept is possible on the first rising edge with reset_n=1. reset_n deassertion is synchronised externally.

## Structure
- Shared package sipo_pkg:
  - localparam defaults: SIPO_DEF_WIDTH=8, SIPO_DEF_MSB_FIRST=1.
  - Function cnt_width(w) returning $clog2(w).
- One sub-module, sipo_out_reg: a WIDTH-parametrised valid/ready holding register with load, transfer and clear. It is reused by the planned PISO successor.
- Top-level contents: sr, bit_count, last-bit detect, word assembly and in_ready logic.

## Test plan
- WIDTH=8, MSB_FIRST=1, out_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles.
  - out_valid=1 for exactly one cycle after the 8th bit; parallel_out=8'hB2; bit_count 0→7→0.
- WIDTH=8, MSB_FIRST=0, same bits → parallel_out=8'h4D.
- in_valid gaps: the same 8 bits with in_valid low 2 cycles between each bit.
  - Word still 8'hB2; bit_count holds during gaps; out_valid stays 0 until the 8th accept.
- Backpressure, WIDTH=4, MSB_FIRST=1, out_ready=0, stream 1,0,1,0 then 1,1,0,0.
  - First word 4'hA held.
  - in_ready drops at bit_count=3 of the second word.
  - Raising out_ready: 4'hA transfers and 4'hC loads on the same edge; out_valid stays 1.
- Asynchronous reset_n low mid-word, after 3 bits of WIDTH=8.
  - bit_count=0, out_valid=0, parallel_out=0 immediately, without a clock edge.
  - Next 8 bits 8'hB2 decode correctly.
- clear asserted on the cycle the 8th bit is accepted → no word emitted, out_valid=0, bit_count=0; the next full word decodes correctly.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel deserializer family.
// Holds the default word geometry and a helper that derives the width
// of the bit counter from the word width.
package sipo_pkg;

    localparam int SIPO_DEF_WIDTH     = 8;
    localparam bit SIPO_DEF_MSB_FIRST = 1'b1;

    // Number of bits needed to count 0..w-1.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Handshake bundle of the deserializer.
//   serial_in / in_valid / in_ready      : bit-serial input side
//   parallel_out / out_valid / out_ready : word output side
//   bit_count                            : bits held in the current partial word
// slave  : the deserializer itself
// master : the environment (bit source plus word consumer)
interface sipo_deserializer_if #(
    parameter int WIDTH = sipo_pkg::SIPO_DEF_WIDTH
);
    import sipo_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);

    logic             serial_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] bit_count;

    modport slave (
        input  serial_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output parallel_out,
        output out_valid,
        output bit_count
    );

    modport master (
        output serial_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  parallel_out,
        input  out_valid,
        input  bit_count
    );

endinterface

// File: rtl/sipo_out_reg.sv
// Valid/ready word holding register.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear of data and valid (highest priority)
//   load         : capture load_data this cycle
//   load_data    : word to capture
//   load_ready   : a load this cycle will not overwrite an un-taken word
//   out_ready    : consumer takes the held word this cycle
//   data         : held word
//   valid        : data holds a word not yet taken
// A load and a transfer on the same edge replace the old word with the
// new one and keep valid high. The producer must respect load_ready.
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            // Data is left in place after a transfer; only valid drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign load_ready = !valid_q || out_ready;
    assign data       = data_q;
    assign valid      = valid_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Parametrised serial-to-parallel deserializer.
//   clk      : sole clock, rising edge
//   reset_n  : asynchronous active-low reset
//   clear    : synchronous clear of the partial word and the held word
//   bus      : slave side of sipo_deserializer_if
//              (serial_in/in_valid/in_ready, parallel_out/out_valid/out_ready,
//               bit_count)
// Collects WIDTH bits, MSB-first or LSB-first, and hands the completed
// word to a holding register. One bit per cycle is sustained when the
// consumer keeps out_ready high.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter bit MSB_FIRST = SIPO_DEF_MSB_FIRST
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    sipo_deserializer_if.slave   bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic [WIDTH-1:0] sr_shift;
    logic             accept;
    logic             last_bit;
    logic             load;
    logic             load_ready;
    logic             in_ready;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic             b);
        if (MSB_FIRST) begin
            return {cur[WIDTH-2:0], b};
        end
        return {b, cur[WIDTH-1:1]};
    endfunction

    // The completed word includes the bit arriving this cycle, so it is
    // taken from the combinational shift result rather than sr_q.
    assign sr_shift = shift_in(sr_q, bus.serial_in);
    assign last_bit = (bit_count_q == LAST_CNT);

    // Stall only when the final bit would overwrite a word nobody has taken.
    assign in_ready = !(last_bit && !load_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        sr_d        = sr_q;
        bit_count_d = bit_count_q;
        load        = 1'b0;
        if (clear) begin
            sr_d        = '0;
            bit_count_d = '0;
        end else if (accept) begin
            sr_d = sr_shift;
            if (last_bit) begin
                bit_count_d = '0;
                load        = 1'b1;
            end else begin
                bit_count_d = bit_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q        <= '0;
            bit_count_q <= '0;
        end else begin
            sr_q        <= sr_d;
            bit_count_q <= bit_count_d;
        end
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .load       (load),
        .load_data  (sr_shift),
        .load_ready (load_ready),
        .out_ready  (bus.out_ready),
        .data       (bus.parallel_out),
        .valid      (bus.out_valid)
    );

    assign bus.in_ready  = in_ready;
    assign bus.bit_count = bit_count_q;

endmodule
